gray_cnt: RTL and testbench

- Parametrised up/down counter that holds its state in binary and in Gray code, both driven directly from flops.
- Building block for CDC-safe pointers: FIFO read/write pointers and cross-domain event counters.
- Generalises the combinational bin/gray converter pair with: registered state, up/down counting, load of a Gray value, wrap or saturate mode, and boundary flags.
- gray_o must come straight from a flop so that a downstream synchroniser never samples a combinational glitch.

---
 rtl/gray_pkg.sv | 20 ++
 rtl/bin_to_gray.sv | 13 +
 rtl/gray_to_bin.sv | 13 +
 rtl/gray_cnt.sv | 98 +++++++++
 tb/tb_gray_cnt.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared binary/Gray conversion helpers, width-generic up to MAX_W bits.
package gray_pkg;

    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended inputs keep the upper prefix-XOR bits at zero, so any narrower width works.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray converter.
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray_c
);

    assign gray_c = W'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin_c
);

    assign bin_c = W'(gray2bin(MAX_W'(gray)));

endmodule

// File: rtl/gray_cnt.sv
// Up/down counter holding its value in both binary and Gray flops, with load,
// wrap/saturate boundaries and a registered wrap pulse.
module gray_cnt
    import gray_pkg::*;
#(
    parameter int unsigned     CNT_W    = 8,
    parameter bit              DOWN_EN  = 1'b1,
    parameter bit              SAT_MODE = 1'b0,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en_i,
    input  logic             down_i,
    input  logic             ld_v_i,
    input  logic [CNT_W-1:0] ld_gray_i,
    output logic [CNT_W-1:0] gray_o,
    output logic [CNT_W-1:0] bin_o,
    output logic             wrap_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [CNT_W-1:0] bin_q;
    logic [CNT_W-1:0] gray_q;
    logic             wrap_q;
    logic [CNT_W-1:0] bin_next;
    logic [CNT_W-1:0] cnt_gray_c;
    logic [CNT_W-1:0] ld_bin_c;
    logic             wrap_next;
    logic             count_down;

    gray_to_bin #(.W(CNT_W)) m_gray_to_bin (
        .gray  (ld_gray_i),
        .bin_c (ld_bin_c)
    );

    bin_to_gray #(.W(CNT_W)) m_bin_to_gray (
        .bin    (bin_next),
        .gray_c (cnt_gray_c)
    );

    assign count_down = DOWN_EN & down_i;

    // Next count value; hold and saturation both leave bin_next == bin_q.
    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (en_i) begin
            if (count_down) begin
                if (bin_q == '0) begin
                    if (!SAT_MODE) begin
                        bin_next  = ALL_ONES;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_q - CNT_W'(1);
                end
            end else begin
                if (bin_q == ALL_ONES) begin
                    if (!SAT_MODE) begin
                        bin_next  = '0;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_q + CNT_W'(1);
                end
            end
        end
    end

    // Both registers load from next-state logic so gray_o never sees a converter glitch.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bin_q  <= RST_VAL;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else if (ld_v_i) begin
            bin_q  <= ld_bin_c;
            gray_q <= ld_gray_i;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= cnt_gray_c;
            wrap_q <= wrap_next;
        end
    end

    assign gray_o   = gray_q;
    assign bin_o    = bin_q;
    assign wrap_o   = wrap_q;
    assign at_max_o = (bin_q == ALL_ONES);
    assign at_min_o = (bin_q == '0);

endmodule

// File: tb/tb_gray_cnt.sv
// Self-checking bench: four gray_cnt configurations against an arithmetic reference model.
module tb_gray_cnt;

    logic clk;
    logic nreset;

    logic       a_en, a_down, a_ld;
    logic [3:0] a_ldg, a_gray, a_bin;
    logic       a_wrap, a_max, a_min;

    logic       b_en, b_down, b_ld;
    logic [3:0] b_ldg, b_gray, b_bin;
    logic       b_wrap, b_max, b_min;

    logic       c_en, c_down, c_ld;
    logic [3:0] c_ldg, c_gray, c_bin;
    logic       c_wrap, c_max, c_min;

    logic       d_en, d_down, d_ld;
    logic [7:0] d_ldg, d_gray, d_bin;
    logic       d_wrap, d_max, d_min;

    int checks   = 0;
    int failures = 0;

    int ma, mb, mc, md;
    bit wa, wb, wc, wd;
    int ka, kb, kc, kd;
    int pa, pb, pc, pd;

    gray_cnt #(.CNT_W(4), .DOWN_EN(1'b1), .SAT_MODE(1'b0), .RST_VAL(4'd5)) dut_a (
        .clk(clk), .nreset(nreset), .en_i(a_en), .down_i(a_down), .ld_v_i(a_ld),
        .ld_gray_i(a_ldg), .gray_o(a_gray), .bin_o(a_bin), .wrap_o(a_wrap),
        .at_max_o(a_max), .at_min_o(a_min));

    gray_cnt #(.CNT_W(4), .DOWN_EN(1'b1), .SAT_MODE(1'b1), .RST_VAL(4'd0)) dut_b (
        .clk(clk), .nreset(nreset), .en_i(b_en), .down_i(b_down), .ld_v_i(b_ld),
        .ld_gray_i(b_ldg), .gray_o(b_gray), .bin_o(b_bin), .wrap_o(b_wrap),
        .at_max_o(b_max), .at_min_o(b_min));

    gray_cnt #(.CNT_W(4), .DOWN_EN(1'b0), .SAT_MODE(1'b0), .RST_VAL(4'd3)) dut_c (
        .clk(clk), .nreset(nreset), .en_i(c_en), .down_i(c_down), .ld_v_i(c_ld),
        .ld_gray_i(c_ldg), .gray_o(c_gray), .bin_o(c_bin), .wrap_o(c_wrap),
        .at_max_o(c_max), .at_min_o(c_min));

    gray_cnt #(.CNT_W(8)) dut_d (
        .clk(clk), .nreset(nreset), .en_i(d_en), .down_i(d_down), .ld_v_i(d_ld),
        .ld_gray_i(d_ldg), .gray_o(d_gray), .bin_o(d_bin), .wrap_o(d_wrap),
        .at_max_o(d_max), .at_min_o(d_min));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Decode a Gray code by searching for the binary value whose Gray image matches.
    function automatic int gray_search(input int w, input int g);
        for (int b = 0; b < (1 << w); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    // kind: 0 = value unchanged, 1 = single count step, 2 = load/reset (unconstrained)
    task automatic model_step(input int w, input bit den, input bit sat,
                              input bit en, input bit down, input bit ld, input int ldg,
                              input int m_in, output int m_out, output bit wr, output int kind);
        int mx;
        mx    = (1 << w) - 1;
        m_out = m_in;
        wr    = 1'b0;
        kind  = 0;
        if (ld) begin
            m_out = gray_search(w, ldg);
            kind  = 2;
        end else if (en) begin
            if (den && down) begin
                if (m_in == 0) begin
                    if (!sat) begin m_out = mx; wr = 1'b1; kind = 1; end
                end else begin
                    m_out = m_in - 1; kind = 1;
                end
            end else begin
                if (m_in == mx) begin
                    if (!sat) begin m_out = 0; wr = 1'b1; kind = 1; end
                end else begin
                    m_out = m_in + 1; kind = 1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ma = 5; mb = 0; mc = 3; md = 0;
            wa = 0; wb = 0; wc = 0; wd = 0;
            ka = 2; kb = 2; kc = 2; kd = 2;
        end else begin
            model_step(4, 1'b1, 1'b0, a_en, a_down, a_ld, int'(a_ldg), ma, ma, wa, ka);
            model_step(4, 1'b1, 1'b1, b_en, b_down, b_ld, int'(b_ldg), mb, mb, wb, kb);
            model_step(4, 1'b0, 1'b0, c_en, c_down, c_ld, int'(c_ldg), mc, mc, wc, kc);
            model_step(8, 1'b1, 1'b0, d_en, d_down, d_ld, int'(d_ldg), md, md, wd, kd);
        end
    end

    task automatic cmp(input string nm, input int w, input int bin, input int gray,
                       input int wrap, input int amax, input int amin,
                       input int m, input bit wr, input int kind, input int pg);
        int mx;
        mx = (1 << w) - 1;
        chk({nm, "_bin"}, bin, m);
        chk({nm, "_gray"}, gray, m ^ (m >> 1));
        chk({nm, "_wrap"}, wrap, int'(wr));
        chk({nm, "_at_max"}, amax, int'(m == mx));
        chk({nm, "_at_min"}, amin, int'(m == 0));
        if (kind == 1) chk({nm, "_gray_step_bits"}, $countones(gray ^ pg), 1);
        else if (kind == 0) chk({nm, "_gray_hold_bits"}, $countones(gray ^ pg), 0);
    endtask

    always @(negedge clk) begin
        if (nreset) begin
            cmp("a", 4, int'(a_bin), int'(a_gray), int'(a_wrap), int'(a_max), int'(a_min), ma, wa, ka, pa);
            cmp("b", 4, int'(b_bin), int'(b_gray), int'(b_wrap), int'(b_max), int'(b_min), mb, wb, kb, pb);
            cmp("c", 4, int'(c_bin), int'(c_gray), int'(c_wrap), int'(c_max), int'(c_min), mc, wc, kc, pc);
            cmp("d", 8, int'(d_bin), int'(d_gray), int'(d_wrap), int'(d_max), int'(d_min), md, wd, kd, pd);
        end
        pa = int'(a_gray); pb = int'(b_gray); pc = int'(c_gray); pd = int'(d_gray);
    end

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic idle_all;
        a_en = 0; a_down = 0; a_ld = 0; a_ldg = '0;
        b_en = 0; b_down = 0; b_ld = 0; b_ldg = '0;
        c_en = 0; c_down = 0; c_ld = 0; c_ldg = '0;
        d_en = 0; d_down = 0; d_ld = 0; d_ldg = '0;
    endtask

    task automatic randomize_inputs;
        a_en = 1'($urandom_range(0, 1)); a_down = 1'($urandom_range(0, 1));
        a_ld = ($urandom_range(0, 7) == 0); a_ldg = 4'($urandom_range(0, 15));
        b_en = 1'($urandom_range(0, 1)); b_down = 1'($urandom_range(0, 1));
        b_ld = ($urandom_range(0, 7) == 0); b_ldg = 4'($urandom_range(0, 15));
        c_en = 1'($urandom_range(0, 1)); c_down = 1'($urandom_range(0, 1));
        c_ld = ($urandom_range(0, 7) == 0); c_ldg = 4'($urandom_range(0, 15));
        d_en = 1'($urandom_range(0, 1)); d_down = 1'($urandom_range(0, 1));
        d_ld = ($urandom_range(0, 15) == 0); d_ldg = 8'($urandom_range(0, 255));
    endtask

    int wraps;

    initial begin
        idle_all();
        nreset = 1'b0;
        #7;
        chk("rst_a_bin", int'(a_bin), 5);
        chk("rst_a_gray", int'(a_gray), 7);
        chk("rst_a_wrap", int'(a_wrap), 0);
        chk("rst_c_bin", int'(c_bin), 3);
        tick();
        nreset = 1'b1;

        // C: down_i ignored when down counting is disabled, then hold
        c_en = 1; c_down = 1;
        tick();
        chk("c_up_ignores_down", int'(c_bin), 4);
        c_en = 0;
        tick();
        chk("c_hold_bin", int'(c_bin), 4);
        chk("c_hold_gray", int'(c_gray), 6);
        c_down = 0;

        // A: wrap-mode up count from 0 for 20 steps
        a_ld = 1; a_ldg = 4'd0;
        tick();
        a_ld = 0; a_en = 1; a_down = 0;
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            wraps += int'(a_wrap);
            if (i == 15) begin
                chk("a_wrap_at_zero_bin", int'(a_bin), 0);
                chk("a_wrap_at_zero_pulse", int'(a_wrap), 1);
            end
        end
        chk("a_wrap_count", wraps, 1);
        chk("a_after_20", int'(a_bin), 4);

        // A: down from 1 through the lower boundary
        a_en = 0; a_ld = 1; a_ldg = 4'd1;
        tick();
        a_ld = 0; a_en = 1; a_down = 1;
        tick();
        chk("a_down_to_0", int'(a_bin), 0);
        chk("a_down_to_0_wrap", int'(a_wrap), 0);
        tick();
        chk("a_down_to_15", int'(a_bin), 15);
        chk("a_down_to_15_gray", int'(a_gray), 8);
        chk("a_down_wrap_pulse", int'(a_wrap), 1);
        a_down = 0;

        // A: load beats enable, then counts on
        a_ld = 1; a_ldg = 4'b1100; a_en = 1;
        tick();
        chk("a_load_bin", int'(a_bin), 8);
        chk("a_load_gray", int'(a_gray), 12);
        chk("a_load_wrap", int'(a_wrap), 0);
        a_ld = 0;
        tick();
        chk("a_after_load_bin", int'(a_bin), 9);
        chk("a_after_load_gray", int'(a_gray), 13);

        // Asynchronous reset mid-cycle
        a_en = 0;
        nreset = 1'b0;
        #1;
        chk("async_rst_a_bin", int'(a_bin), 5);
        chk("async_rst_a_gray", int'(a_gray), 7);
        chk("async_rst_a_wrap", int'(a_wrap), 0);
        tick();
        nreset = 1'b1;

        // B: saturate at both boundaries
        b_ld = 1; b_ldg = 4'd0;
        tick();
        b_ld = 0; b_en = 1; b_down = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_sat_min_bin", int'(b_bin), 0);
            chk("b_sat_min_flag", int'(b_min), 1);
            chk("b_sat_min_wrap", int'(b_wrap), 0);
        end
        b_en = 0; b_ld = 1; b_ldg = 4'b1000;
        tick();
        b_ld = 0; b_en = 1; b_down = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_sat_max_bin", int'(b_bin), 15);
            chk("b_sat_max_flag", int'(b_max), 1);
            chk("b_sat_max_wrap", int'(b_wrap), 0);
        end
        b_en = 0;

        // D: exhaustive 8-bit up sweep
        d_ld = 1; d_ldg = 8'd0;
        tick();
        d_ld = 0; d_en = 1; d_down = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("d_sweep_consistent", int'(d_bin), gray_search(8, int'(d_gray)));
        end
        chk("d_sweep_end", int'(d_bin), 0);

        // Randomized traffic on all instances
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            tick();
        end
        idle_all();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
